// File: rtl/sti_dac_pkg.sv
// Shared types and sizing helpers for the serial-transmit / data-arrangement controller.
// Helpers are parameter-free so any instance size can use them.
package sti_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int frame_len(input int len_code);
        return 8 * (len_code + 1);
    endfunction

    function automatic int cap_bytes(input int banks, input int addr_w);
        return banks * 2 * (1 << addr_w);
    endfunction

endpackage

// File: rtl/sti_frame_shifter.sv
// Builds the F-bit frame from an accepted word and serialises it one bit per i_shift.
// Frame is loaded on the accept edge; first bit is on o_bit the next cycle, o_last marks bit F.
module sti_frame_shifter
    import sti_dac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_fill,
    input  logic              i_low,
    input  logic              i_msb,
    output logic              o_bit,
    output logic              o_last
);

    localparam int FMAX = 8 * (1 << LEN_W);
    localparam int CW   = $clog2(FMAX);

    logic [FMAX-1:0] r_sh;
    logic            r_msb;
    logic [CW-1:0]   r_cnt;

    int              w_flen;
    logic [FMAX-1:0] w_frame;
    logic [FMAX-1:0] w_aligned;

    // Frame is right-aligned in FMAX bits; frame bit F-1 is its MSB.
    function automatic logic [FMAX-1:0] build_frame(input logic [DATA_W-1:0] data,
                                                    input int flen,
                                                    input logic fill,
                                                    input logic low);
        logic [FMAX-1:0] ext;
        logic [FMAX-1:0] mask;
        ext  = FMAX'(data);
        mask = ~({FMAX{1'b1}} << flen);
        if (flen >= DATA_W)
            build_frame = fill ? (ext << (flen - DATA_W)) : ext;
        else
            build_frame = low ? (ext >> (DATA_W - flen)) : (ext & mask);
    endfunction

    always_comb begin
        w_flen    = frame_len(int'(i_length));
        w_frame   = build_frame(i_data, w_flen, i_fill, i_low);
        // MSB-first frames are left-justified so both orders shift a fixed end out.
        w_aligned = i_msb ? (w_frame << (FMAX - w_flen)) : w_frame;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh  <= '0;
            r_msb <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= w_aligned;
            r_msb <= i_msb;
            r_cnt <= CW'(w_flen - 1);
        end else if (i_shift) begin
            r_sh  <= r_msb ? {r_sh[FMAX-2:0], 1'b0} : {1'b0, r_sh[FMAX-1:1]};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_bit  = r_msb ? r_sh[FMAX-1] : r_sh[0];
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sti_dac_gen.sv
// Serial frame transmitter that packs the bit stream into bytes and writes them checkerboard-wise
// into odd/even memory banks; pi_ready only in IDLE, write lands 1 cycle after each 8th bit.
module sti_dac_gen
    import sti_dac_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 2,
    parameter int BANKS   = 4,
    parameter int ADDR_W  = 5,
    parameter int CHK_BIT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    output logic              pi_ready,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_low,
    input  logic              pi_msb,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic [7:0]        oem_dataout,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [BANKS-1:0]  oem_odd_wr,
    output logic [BANKS-1:0]  oem_even_wr,
    output logic              oem_finish
);

    localparam int CAP = cap_bytes(BANKS, ADDR_W);
    localparam int NW  = $clog2(CAP + 1);
    localparam int BW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [NW-1:0] CAP_N  = NW'(CAP);
    localparam logic [NW-1:0] LAST_N = NW'(CAP - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [NW-1:0]     r_n;
    logic [6:0]        r_byte;
    logic [2:0]        r_bcnt;
    logic [7:0]        r_dataout;
    logic [ADDR_W-1:0] r_addr;
    logic [BANKS-1:0]  r_odd;
    logic [BANKS-1:0]  r_even;

    logic              w_accept;
    logic              w_shift;
    logic              w_bit;
    logic              w_last;
    logic              w_wr;
    logic [7:0]        w_wr_dat;
    logic [ADDR_W-1:0] w_addr;
    logic [BW-1:0]     w_bank;
    logic              w_odd;
    logic [BANKS-1:0]  w_onehot;

    assign w_shift = (r_state == SHIFT);

    sti_frame_shifter #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_accept),
        .i_shift  (w_shift),
        .i_data   (pi_data),
        .i_length (pi_length),
        .i_fill   (pi_fill),
        .i_low    (pi_low),
        .i_msb    (pi_msb),
        .o_bit    (w_bit),
        .o_last   (w_last)
    );

    // Byte n -> pair index p = n>>1: address is the low part of p, bank the high part.
    assign w_addr   = r_n[ADDR_W:1];
    assign w_bank   = r_n[ADDR_W+1 +: BW];
    assign w_odd    = (r_n[0] == w_addr[CHK_BIT]);
    assign w_onehot = BANKS'(1) << w_bank;

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_wr       = 1'b0;
        w_wr_dat   = '0;
        case (r_state)
            IDLE: begin
                if (pi_end) begin
                    w_state_nx = FLUSH;
                end else if (load) begin
                    w_accept   = 1'b1;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bcnt == 3'd7) begin
                    w_wr     = 1'b1;
                    w_wr_dat = {r_byte, w_bit};
                end
                if (w_wr && (r_n == LAST_N))
                    w_state_nx = DONE;
                else if (w_last)
                    w_state_nx = IDLE;
            end
            FLUSH: begin
                if (r_n == CAP_N) begin
                    w_state_nx = DONE;
                end else begin
                    w_wr = 1'b1;
                    if (r_n == LAST_N)
                        w_state_nx = DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_byte    <= '0;
            r_bcnt    <= '0;
            r_dataout <= '0;
            r_addr    <= '0;
            r_odd     <= '0;
            r_even    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_byte <= '0;
                r_bcnt <= '0;
            end else if (w_shift) begin
                r_byte <= {r_byte[5:0], w_bit};
                r_bcnt <= r_bcnt + 3'd1;
            end
            if (w_wr)
                r_n <= r_n + NW'(1);
            // Write bus is zero whenever no strobe is active.
            r_dataout <= w_wr ? w_wr_dat : '0;
            r_addr    <= w_wr ? w_addr : '0;
            r_odd     <= (w_wr && w_odd)  ? w_onehot : '0;
            r_even    <= (w_wr && !w_odd) ? w_onehot : '0;
        end
    end

    assign pi_ready    = (r_state == IDLE);
    assign oem_finish  = (r_state == DONE);
    assign so_valid    = w_shift;
    assign so_data     = w_shift & w_bit;
    assign oem_dataout = r_dataout;
    assign oem_addr    = r_addr;
    assign oem_odd_wr  = r_odd;
    assign oem_even_wr = r_even;

endmodule

// File: tb/tb_sti_dac_gen.sv
// Scoreboard bench for sti_dac_gen: expected serial bits and memory writes are queued at stimulus
// time and compared as the DUT produces them.
module tb_sti_dac_gen;

    localparam int CAP = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic        pi_ready;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_low;
    logic        pi_msb;
    logic        pi_end;
    logic        so_data;
    logic        so_valid;
    logic [7:0]  oem_dataout;
    logic [4:0]  oem_addr;
    logic [3:0]  oem_odd_wr;
    logic [3:0]  oem_even_wr;
    logic        oem_finish;

    sti_dac_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .pi_ready    (pi_ready),
        .pi_data     (pi_data),
        .pi_length   (pi_length),
        .pi_fill     (pi_fill),
        .pi_low      (pi_low),
        .pi_msb      (pi_msb),
        .pi_end      (pi_end),
        .so_data     (so_data),
        .so_valid    (so_valid),
        .oem_dataout (oem_dataout),
        .oem_addr    (oem_addr),
        .oem_odd_wr  (oem_odd_wr),
        .oem_even_wr (oem_even_wr),
        .oem_finish  (oem_finish)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic        bits_q[$];
    logic [20:0] wr_q[$];
    int          m_n;
    int          wr_seen;
    logic [20:0] last_wr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] exp_wr(input int n, input logic [7:0] d);
        int         a;
        int         bank;
        logic       odd;
        logic [3:0] sel;
        a    = (n / 2) % 32;
        bank = (n / 2) / 32;
        odd  = ((n % 2) == ((a / 4) % 2));
        sel  = 4'(1 << bank);
        return {d, 5'(a), odd ? sel : 4'd0, odd ? 4'd0 : sel};
    endfunction

    task automatic push_byte(input logic [7:0] d);
        if (m_n < CAP) wr_q.push_back(exp_wr(m_n, d));
        m_n++;
    endtask

    task automatic model_frame(input logic [15:0] d, input logic [1:0] len,
                               input logic fill, input logic low, input logic msb);
        int         f;
        int         hi;
        logic       fr[$];
        logic       tx[$];
        logic [7:0] bv;
        f = 8 * (int'(len) + 1);
        if (f >= 16) begin
            if (!fill) repeat (f - 16) fr.push_back(1'b0);
            for (int i = 15; i >= 0; i--) fr.push_back(d[i]);
            if (fill) repeat (f - 16) fr.push_back(1'b0);
        end else begin
            hi = low ? 15 : f - 1;
            for (int i = hi; i > hi - f; i--) fr.push_back(d[i]);
        end
        for (int i = 0; i < f; i++) tx.push_back(msb ? fr[i] : fr[f - 1 - i]);
        for (int b = 0; b < f / 8; b++) begin
            bv = 8'h00;
            for (int k = 0; k < 8; k++) begin
                bv = {bv[6:0], tx[b*8 + k]};
                bits_q.push_back(tx[b*8 + k]);
            end
            push_byte(bv);
        end
    endtask

    always @(negedge clk) begin
        if (so_valid) begin
            if (bits_q.size() == 0) check_eq("extra_bit", 32'(so_valid), 32'd0);
            else check_eq("so_data", 32'(so_data), 32'(bits_q.pop_front()));
        end
        if (oem_odd_wr != 4'd0 || oem_even_wr != 4'd0) begin
            wr_seen++;
            last_wr = {oem_dataout, oem_addr, oem_odd_wr, oem_even_wr};
            if (wr_q.size() == 0) check_eq("extra_write", 32'({oem_odd_wr, oem_even_wr}), 32'd0);
            else check_eq("mem_write", 32'(last_wr), 32'(wr_q.pop_front()));
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic send(input logic [15:0] d, input logic [1:0] len,
                        input logic fill, input logic low, input logic msb);
        int f;
        int k;
        f = 8 * (int'(len) + 1);
        k = 0;
        while (!pi_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("ready_wait", 32'(pi_ready), 32'd1);
        model_frame(d, len, fill, low, msb);
        pi_data = d; pi_length = len; pi_fill = fill; pi_low = low; pi_msb = msb;
        load = 1'b1;
        @(posedge clk); #1;
        load      = 1'b0;
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom_range(3));
        pi_fill   = 1'($urandom_range(1));
        pi_low    = 1'($urandom_range(1));
        pi_msb    = 1'($urandom_range(1));
        check_eq("first_bit_lat", 32'(so_valid), 32'd1);
        check_eq("busy_ready", 32'(pi_ready), 32'd0);
        repeat (f) @(posedge clk);
        #1;
        check_eq("frame_end_valid", 32'(so_valid), 32'd0);
        check_eq("frame_bits_left", 32'(bits_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bits_q.delete();
        wr_q.delete();
        m_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((bits_q.size() != 0 || wr_q.size() != 0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(bits_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; pi_end = 1'b0;
        pi_data = '0; pi_length = '0; pi_fill = 1'b0; pi_low = 1'b0; pi_msb = 1'b0;
        m_n = 0; wr_seen = 0; last_wr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(pi_ready), 32'd1);
        check_eq("rst_outs", 32'({so_data, so_valid, oem_finish, oem_dataout, oem_addr,
                                  oem_odd_wr, oem_even_wr}), 32'd0);
        do_reset();

        send(16'hA5C3, 2'd1, 1'b0, 1'b0, 1'b1);
        send(16'h8100, 2'd0, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b1);
        send(16'hFFFF, 2'd3, 1'b1, 1'b0, 1'b1);
        send(16'h3C5A, 2'd0, 1'b0, 1'b0, 1'b1);
        send(16'hBEEF, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            send(16'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        drain("drain_mixed");

        do_reset();
        for (int i = 0; i < 4; i++)
            send(16'($urandom), 2'd3, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        drain("drain_checker");

        do_reset();
        send(16'h1357, 2'd1, 1'b0, 1'b0, 1'b1);
        send(16'h2400, 2'd0, 1'b0, 1'b1, 1'b1);
        drain("drain_pre_flush");
        wr_seen = 0;
        for (int n = 3; n < CAP; n++) push_byte(8'h00);
        pi_end = 1'b1;
        load   = 1'b1;
        @(posedge clk); #1;
        pi_end = 1'b0;
        load   = 1'b0;
        check_eq("flush_no_serial", 32'(so_valid), 32'd0);
        for (int k = 0; k < 400 && !oem_finish; k++) begin
            @(posedge clk); #1;
        end
        check_eq("finish", 32'(oem_finish), 32'd1);
        @(posedge clk); #1;
        check_eq("flush_left", 32'(wr_q.size()), 32'd0);
        check_eq("flush_count", 32'(wr_seen), 32'd253);
        check_eq("flush_last", 32'(last_wr), 32'({8'h00, 5'd31, 4'b1000, 4'b0000}));
        check_eq("done_ready", 32'(pi_ready), 32'd0);
        load = 1'b1; pi_end = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        load = 1'b0; pi_end = 1'b0;
        check_eq("done_sticky", 32'(oem_finish), 32'd1);
        check_eq("done_quiet", 32'({so_valid, oem_odd_wr, oem_even_wr}), 32'd0);

        do_reset();
        model_frame(16'hF0F0, 2'd1, 1'b0, 1'b0, 1'b1);
        pi_data = 16'hF0F0; pi_length = 2'd1; pi_fill = 1'b0; pi_low = 1'b0; pi_msb = 1'b1;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_frame_valid", 32'(so_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_outs", 32'({so_data, so_valid, oem_finish, oem_dataout, oem_addr,
                                        oem_odd_wr, oem_even_wr}), 32'd0);
        check_eq("async_rst_ready", 32'(pi_ready), 32'd1);
        bits_q.delete();
        wr_q.delete();
        m_n = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(16'h6B2D, 2'd1, 1'b0, 1'b0, 1'b0);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
